// File: rtl/nonbin_class_updater.sv
// nonbin_class_updater
// Writer-side sequencer for the non-binary class hypervector register.
// Each accepted start walks the segments of one class HV. For each segment it
// reads the accumulators and the query bits, adds or subtracts the bipolar
// query with saturation, and writes the result back to the same segment.
module nonbin_class_updater #(
  parameter int DIMS_PER_CC      = 1024,
  parameter int BITWIDTH_PER_DIM = 9,
  parameter int SEQ_CYCLE_COUNT  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  op_add,
  input  logic [DIMS_PER_CC-1:0]                query_seg_in,
  input  logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] class_seg_in,
  output logic [1:0]                            seg_idx,
  output logic                                  wr_en,
  output logic [DIMS_PER_CC*BITWIDTH_PER_DIM-1:0] wr_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sat_flag
);

  localparam int BW    = BITWIDTH_PER_DIM;
  localparam int SW    = BITWIDTH_PER_DIM + 1;
  localparam int SEG_W = DIMS_PER_CC * BITWIDTH_PER_DIM;

  // Saturation bounds at the widened sum width; the minimum is the one's
  // complement of the maximum (e.g. +255 / -256 for 9-bit accumulators).
  localparam logic signed [SW-1:0] C_MAX  = SW'((2 ** (BITWIDTH_PER_DIM - 1)) - 1);
  localparam logic signed [SW-1:0] C_MIN  = ~C_MAX;
  localparam logic signed [SW-1:0] C_ONE  = SW'(1);
  localparam logic [1:0]           C_LAST = 2'(SEQ_CYCLE_COUNT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_seg_idx;
  logic             r_wr_en;
  logic [SEG_W-1:0] r_wr_data;
  logic             r_busy;
  logic             r_done;
  logic             r_sat_flag;
  logic             r_op_add;

  logic [SEG_W-1:0] w_next;
  logic             w_sat;

  // Per-dimension saturating update of the segment currently on the read mux.
  always_comb begin
    logic signed [SW-1:0] w_cur;
    logic signed [SW-1:0] w_sum;
    w_next = '0;
    w_sat  = 1'b0;
    w_cur  = '0;
    w_sum  = '0;
    for (int d = 0; d < DIMS_PER_CC; d++) begin
      w_cur = {class_seg_in[d*BW + BW - 1], class_seg_in[d*BW +: BW]};
      // The step is +1 exactly when the query polarity agrees with the op.
      if (query_seg_in[d] == r_op_add) begin
        w_sum = w_cur + C_ONE;
      end else begin
        w_sum = w_cur - C_ONE;
      end
      if (w_sum > C_MAX) begin
        w_next[d*BW +: BW] = C_MAX[BW-1:0];
        w_sat              = 1'b1;
      end else if (w_sum < C_MIN) begin
        w_next[d*BW +: BW] = C_MIN[BW-1:0];
        w_sat              = 1'b1;
      end else begin
        w_next[d*BW +: BW] = w_sum[BW-1:0];
      end
    end
  end

  // Sequencer: IDLE -> (RD -> WR) per segment -> DONE, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_seg_idx  <= 2'd0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sat_flag <= 1'b0;
      r_op_add   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          if (start) begin
            r_state    <= S_RD;
            r_seg_idx  <= 2'd0;
            r_op_add   <= op_add;
            r_sat_flag <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RD: begin
          r_wr_data  <= w_next;
          r_sat_flag <= r_sat_flag | w_sat;
          r_wr_en    <= 1'b1;
          r_state    <= S_WR;
        end
        S_WR: begin
          r_wr_en <= 1'b0;
          if (r_seg_idx == C_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_seg_idx <= r_seg_idx + 2'd1;
            r_state   <= S_RD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign seg_idx  = r_seg_idx;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sat_flag = r_sat_flag;

endmodule

// File: tb/tb_nonbin_class_updater.sv
// Directed bench for nonbin_class_updater with a segment scoreboard.
module tb_nonbin_class_updater;

  localparam int D  = 1024;
  localparam int BW = 9;
  localparam int W  = D * BW;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_add;
  logic [D-1:0] query_seg_in;
  logic [W-1:0] class_seg_in;
  logic [1:0]   seg_idx;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         sat_flag;

  // Bench-owned class register and query storage, read combinationally.
  logic [W-1:0] cls_mem [4];
  logic [D-1:0] qry_mem [4];

  logic [W-1:0] exp_data_q [$];
  logic [1:0]   exp_seg_q  [$];
  logic [W-1:0] cap        [4];
  logic [W-1:0] last_exp;

  int checks = 0;
  int errors = 0;

  assign class_seg_in = cls_mem[seg_idx];
  assign query_seg_in = qry_mem[seg_idx];

  always #5 clk = ~clk;

  nonbin_class_updater #(
    .DIMS_PER_CC      (D),
    .BITWIDTH_PER_DIM (BW),
    .SEQ_CYCLE_COUNT  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_add       (op_add),
    .query_seg_in (query_seg_in),
    .class_seg_in (class_seg_in),
    .seg_idx      (seg_idx),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .sat_flag     (sat_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    int first;
    first = -1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      for (int d = D - 1; d >= 0; d--) begin
        if (obs[d*BW +: BW] !== exp[d*BW +: BW]) first = d;
      end
      if (first < 0) first = 0;
      $error("FAIL %s dim=%0d observed=%0h expected=%0h", tag, first,
             obs[first*BW +: BW], exp[first*BW +: BW]);
    end
  endtask

  // Reference: bipolar step, saturate to [-256, +255].
  function automatic void model(input logic [W-1:0] c, input logic [D-1:0] q,
                                input logic add, output logic [W-1:0] r,
                                output logic s);
    int v;
    int qv;
    int dv;
    s = 1'b0;
    r = '0;
    for (int d = 0; d < D; d++) begin
      v  = $signed(c[d*BW +: BW]);
      qv = q[d] ? 1 : -1;
      dv = add ? qv : -qv;
      v  = v + dv;
      if (v > 255) begin
        v = 255;
        s = 1'b1;
      end else if (v < -256) begin
        v = -256;
        s = 1'b1;
      end
      r[d*BW +: BW] = v[8:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_all(input logic [8:0] val, input logic qbit);
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < D; d++) cls_mem[s][d*BW +: BW] = val;
      qry_mem[s] = {D{qbit}};
    end
  endtask

  // One update starting in the current (idle) cycle T; returns in cycle T+10.
  task automatic run_op(input string tag, input logic add, input bit glitch);
    logic         s_all;
    logic         s;
    logic [W-1:0] r;
    logic [W-1:0] e;
    logic [1:0]   es;
    s_all = 1'b0;
    for (int sg = 0; sg < 4; sg++) begin
      model(cls_mem[sg], qry_mem[sg], add, r, s);
      exp_data_q.push_back(r);
      exp_seg_q.push_back(2'(sg));
      s_all = s_all | s;
    end
    start  = 1'b1;
    op_add = add;
    for (int k = 1; k <= 9; k++) begin
      tick();
      start = glitch && (k == 3 || k == 9);
      if (k == 1) op_add = ~add;
      chk({tag, ":busy"}, 32'(busy), 32'd1);
      chk({tag, ":done"}, 32'(done), 32'(k == 9));
      chk({tag, ":wr_en"}, 32'(wr_en), 32'((k % 2 == 0) && (k <= 8)));
      if (k <= 8) chk({tag, ":seg_idx"}, 32'(seg_idx), 32'((k - 1) / 2));
      if (k == 1) chk({tag, ":sat_clr"}, 32'(sat_flag), 32'd0);
      if (wr_en) begin
        if (exp_data_q.size() == 0) begin
          chk({tag, ":unexpected_wr"}, 32'd1, 32'd0);
        end else begin
          e  = exp_data_q.pop_front();
          es = exp_seg_q.pop_front();
          chk({tag, ":wr_seg"}, 32'(seg_idx), 32'(es));
          chk_seg({tag, ":wr_data"}, wr_data, e);
          cap[seg_idx] = wr_data;
          last_exp     = e;
        end
      end
    end
    chk({tag, ":sat_flag"}, 32'(sat_flag), 32'(s_all));
    tick();
    start = 1'b0;
    chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
    chk({tag, ":idle_done"}, 32'(done), 32'd0);
    chk({tag, ":idle_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, ":sat_hold"}, 32'(sat_flag), 32'(s_all));
    chk_seg({tag, ":wr_data_hold"}, wr_data, last_exp);
    chk({tag, ":writes_left"}, 32'(exp_data_q.size()), 32'd0);
    exp_data_q.delete();
    exp_seg_q.delete();
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op_add = 1'b0;
    last_exp = '0;
    fill_all(9'h000, 1'b1);
    tick();
    tick();
    chk("rst:seg_idx", 32'(seg_idx), 32'd0);
    chk("rst:wr_en", 32'(wr_en), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:sat_flag", 32'(sat_flag), 32'd0);
    chk_seg("rst:wr_data", wr_data, '0);
    rst = 1'b0;
    tick();
    chk("post_rst:busy", 32'(busy), 32'd0);

    // Zero class, all-ones query, reinforce: every dim becomes +1.
    fill_all(9'h000, 1'b1);
    run_op("zero_add", 1'b1, 1'b0);
    chk("zero_add:dim0", 32'(cap[0][8:0]), 32'h001);

    // Upper bound: clamp when reinforcing, inward move when penalizing.
    fill_all(9'h0FF, 1'b1);
    run_op("max_add", 1'b1, 1'b0);
    chk("max_add:dim5", 32'(cap[3][5*BW +: BW]), 32'h0FF);
    fill_all(9'h0FF, 1'b1);
    run_op("max_sub", 1'b0, 1'b0);
    chk("max_sub:dim7", 32'(cap[1][7*BW +: BW]), 32'h0FE);

    // Lower bound with an all-zeros query.
    fill_all(9'h100, 1'b0);
    run_op("min_add", 1'b1, 1'b0);
    chk("min_add:dim3", 32'(cap[2][3*BW +: BW]), 32'h100);
    fill_all(9'h100, 1'b0);
    run_op("min_sub", 1'b0, 1'b0);
    chk("min_sub:dim3", 32'(cap[2][3*BW +: BW]), 32'h101);

    // Mixed random content with two directed dims in segment 2.
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < D; d++) begin
        cls_mem[s][d*BW +: BW] = 9'($urandom_range(0, 511));
        qry_mem[s][d]          = 1'($urandom_range(0, 1));
      end
    end
    cls_mem[2][8:0]  = 9'd5;
    qry_mem[2][0]    = 1'b0;
    cls_mem[2][17:9] = 9'h1FD;
    qry_mem[2][1]    = 1'b1;
    run_op("mixed_sub", 1'b0, 1'b0);
    chk("mixed_sub:s2d0", 32'(cap[2][8:0]), 32'h006);
    chk("mixed_sub:s2d1", 32'(cap[2][17:9]), 32'h1FC);

    // Stray starts during RD and DONE are ignored; back-to-back start at T+10.
    fill_all(9'h0FF, 1'b1);
    run_op("glitch", 1'b1, 1'b1);
    fill_all(9'h000, 1'b1);
    run_op("b2b", 1'b1, 1'b0);

    // Asynchronous reset in the middle of an operation.
    fill_all(9'h0FF, 1'b1);
    start  = 1'b1;
    op_add = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start = 1'b0;
    end
    chk("mid:seg_idx", 32'(seg_idx), 32'd2);
    chk("mid:sat_flag", 32'(sat_flag), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst:seg_idx", 32'(seg_idx), 32'd0);
    chk("arst:wr_en", 32'(wr_en), 32'd0);
    chk("arst:busy", 32'(busy), 32'd0);
    chk("arst:done", 32'(done), 32'd0);
    chk("arst:sat_flag", 32'(sat_flag), 32'd0);
    chk_seg("arst:wr_data", wr_data, '0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_arst:wr_en", 32'(wr_en), 32'd0);
      chk("post_arst:busy", 32'(busy), 32'd0);
    end
    fill_all(9'h123, 1'b0);
    run_op("after_rst", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonbin_class_updater.md
# nonbin_class_updater

Writer-side sequencer for the non-binary class hypervector register used during retraining. On each `start` it walks the four 1024-dimension segments of one class HV. For each segment it reads the current 9-bit signed accumulators and the matching binary query HV segment, then adds or subtracts the bipolar query with saturation. It writes the result back through the register's segment write port, with a single segment index steering both the register's read mux and its write demux.

## Interface
Parameters:
- `DIMS_PER_CC`, 1024, dimensions per segment
- `BITWIDTH_PER_DIM`, 9, signed accumulator width per dimension
- `SEQ_CYCLE_COUNT`, 4, segments per class HV; fixed at 4 (index width 2)

Ports:
- Single clock `clk`; reset `rst`, asynchronous, active-high.
- `clk`  in  1  clock
- `rst`  in  1  asynchronous active-high reset
- `start`  in  1  begin one update; honoured only in IDLE
- `op_add`  in  1  sampled with `start`: 1 = reinforce (add query), 0 = penalize (subtract query)
- `query_seg_in`  in  DIMS_PER_CC  binary query segment for `seg_idx`; bit 1 = +1, bit 0 = -1
- `class_seg_in`  in  DIMS_PER_CC x BITWIDTH_PER_DIM  current class segment for `seg_idx` (register read mux output)
- `seg_idx`  out  2  segment select; drives both register read select and write select
- `wr_en`  out  1  segment write strobe
- `wr_data`  out  DIMS_PER_CC x BITWIDTH_PER_DIM  updated segment
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `sat_flag`  out  1  sticky: some dimension clamped during the current/last operation

## Operation
- FSM states: IDLE, RD, WR, DONE.
  - IDLE: `start`=1 → RD, `seg_idx`←0; latch `op_add`; clear `sat_flag`.
  - RD: compute all dims combinationally from `class_seg_in`/`query_seg_in` and register the result into the `wr_data` register → WR.
  - WR: `wr_en`=1, `seg_idx` held. If `seg_idx`=3 → DONE; else `seg_idx`+1 and → RD.
  - DONE: `done`=1 → IDLE.
- Per dimension d: q = +1 if query bit set, else -1; delta = q if `op_add` else -q.
  - sum = class[d] + delta, computed at 10 bits signed.
  - Clamp to [-256, +255]. Clamping sets `sat_flag` (OR across all dims and segments).
  - A value already at a bound that moves inward is not a saturation.
- `start` in RD/WR/DONE is ignored; `op_add` changes after acceptance are ignored.
- `wr_data` holds its last value outside WR; consumers qualify it with `wr_en` only.
- Reset (any state): IDLE, `seg_idx`=0, `wr_en`=0, `wr_data`=0, `busy`=0, `done`=0, `sat_flag`=0. A partially updated class HV is left as-is; no further writes.

## Timing
- `start` high in cycle T (IDLE):
  - RD at T+1, T+3, T+5, T+7 with `seg_idx`=0,1,2,3.
  - WR at T+2, T+4, T+6, T+8, with `wr_en`=1 and the same `seg_idx`.
  - `done`=1 at T+9.
- `busy`=1 for T+1..T+9 inclusive; the next `start` is accepted at T+10 at the earliest. Total latency is 9 cycles; throughput is one update per 10 cycles.
- `class_seg_in` and `query_seg_in` must be valid in the RD cycle for the `seg_idx` driven that cycle, i.e. a combinational read path.
- Register sampling: the write lands at the clock edge ending WR. The next RD sees the new data only for a different segment, so there is no read-after-write hazard.
- `sat_flag` is valid from T+9 and holds until the next accepted `start`.

## Test plan
- Class all 0, query all 1s, `op_add`=1: four `wr_en` pulses at T+2/4/6/8 with `seg_idx` 0..3; every `wr_data` dim = +1; `done` at T+9; `sat_flag`=0.
- Class all +255, query all 1s, `op_add`=1: `wr_data` stays +255 in all dims; `sat_flag`=1. Repeat with `op_add`=0: result 254 in all dims; `sat_flag`=0.
- Class all -256, query all 0s, `op_add`=1: result -256; `sat_flag`=1. Same inputs with `op_add`=0: result -255; `sat_flag`=0.
- Mixed segment 2 with `op_add`=0, dim0=5 with bit 0 and dim1=-3 with bit 1: dim0=6, dim1=-4. Other segments are unchanged except ±1.
- `start` pulsed at T+3 and T+9: ignored, with exactly 4 writes and 1 `done`. `start` at T+10: new operation, `seg_idx`=0 at T+11, `sat_flag` cleared.
- `rst` asserted at T+5: all outputs 0 immediately (async). No `wr_en` after release; the next `start` runs a full 4-segment sequence from `seg_idx`=0.
